tug_playfield_n: RTL
====================

// Module: tug_playfield_n
// PURPOSE
//   Parametrised tug-of-war playfield: one-hot row of NUM_LIGHTS lights, move left/right on L/R presses.
//   Adds win detection, per-player score counters, a timed win pause and a match-over lock.
//   Sits between the debounced/synchronised key inputs and the LEDR/HEX output drivers.
// PARAMETERS
//   NUM_LIGHTS    9  light count; odd, >=3; centre index C = (NUM_LIGHTS-1)/2
//   SCORE_W       3  score counter width; match ends when a score reaches 2**SCORE_W-1
//   PAUSE_CYCLES  4  cycles the WIN state is held before re-centring; >=1
// PORTS
//   clk          in   1           system clock, all logic on posedge
//   reset        in   1           synchronous, active-low reset (0 = reset)
//   L            in   1           left-player press (pulse, or level with TUG_EDGE_DETECT_EN)
//   R            in   1           right-player press
//   led          out  NUM_LIGHTS  playfield; led[0] rightmost, led[NUM_LIGHTS-1] leftmost
//   winner_valid out  1           high throughout WIN state
//   winner       out  1           1 = left won last point, 0 = right; held until next win
//   score_l      out  SCORE_W     left score
//   score_r      out  SCORE_W     right score
//   match_over   out  1           high in MATCH_OVER
// BEHAVIOUR
//   - Reset (reset==0 at posedge): state=PLAY, led = only led[C], scores=0, winner=0,
//     winner_valid=0, match_over=0, pause counter=0. Reset overrides everything, in any state.
//   - press: pL = L & ~R, pR = R & ~L; L&R together or neither = no move.
//   - PLAY: pL moves lit position one index up, pR one index down, both in 1 cycle (visible next edge).
//     pL with led[NUM_LIGHTS-1] lit -> left point; pR with led[0] lit -> right point.
//   - Point: winner <= side; winner_valid <= 1; that score +1; led <= all 0; pause cnt <= 0;
//     if new score == 2**SCORE_W-1 -> MATCH_OVER, else -> WIN.
//   - WIN: inputs ignored; cnt increments each cycle; at cnt == PAUSE_CYCLES-1 -> PLAY next edge,
//     led <= only led[C], winner_valid <= 0. WIN lasts exactly PAUSE_CYCLES cycles.
//   - MATCH_OVER: led all 0, winner_valid=0, match_over=1, scores frozen; exit only via reset.
//   - Invariant: in PLAY exactly one led bit set; in WIN/MATCH_OVER led == 0.
//   - Scores never wrap: terminal value forces MATCH_OVER before further increments.
// CONFIGURATION
//   TUG_EDGE_DETECT_EN defined: L/R are levels; internal rising-edge detect, one press per 0->1.
//     Edge regs reset to 0, so a key held through reset release counts as one press on the first cycle.
//     Edge regs update in every state, so a key held across WIN does not fire on return to PLAY.
//   TUG_EDGE_DETECT_EN undefined: L/R used directly; every high cycle is one press.
// STRUCTURE
//   Package tug_pkg: typedef enum logic [1:0] {PLAY, WIN, MATCH_OVER} tug_state_t;
//     typedef enum logic {SIDE_R=1'b0, SIDE_L=1'b1} tug_side_t; function centre_idx(n).
//   Sub-module press_edge (1-bit rising-edge detector, sync active-low reset), two instances,
//     instantiated only under TUG_EDGE_DETECT_EN.
//   Top: state register, one-hot position register, pause counter, two score counters.
// TESTING (NUM_LIGHTS=5, SCORE_W=2, PAUSE_CYCLES=2 unless noted)
//   1 reset=0 one cycle, then idle -> led=5'b00100, scores 0, winner_valid=0, match_over=0.
//   2 three L pulses -> led 01000, 10000; third pulse -> led=0, winner_valid=1, winner=1, score_l=1;
//     2 cycles later led=00100, winner_valid=0.
//   3 L=R=1 for 4 cycles from centre -> led stays 00100, no score change.
//   4 R pulses during WIN -> ignored; led stays 0 until PAUSE_CYCLES expire, then 00100.
//   5 three right points -> score_r=3, match_over=1, led=0; further L/R ignored; reset=0 clears all.
//   6 TUG_EDGE_DETECT_EN: L held high 10 cycles -> one move (00100->01000); release/re-press -> 10000.

Source files
------------

// File: rtl/tug_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : tug_pkg                                                 |
// | Purpose  : Shared types and helpers for the tug-of-war playfield.  |
// | Revision : 1.0  initial release                                    |
// +--------------------------------------------------------------------+
package tug_pkg;

  // Top-level game states.
  typedef enum logic [1:0] {
    PLAY       = 2'd0,
    WIN        = 2'd1,
    MATCH_OVER = 2'd2
  } tug_state_t;

  // The player who took the last point.
  typedef enum logic {
    SIDE_R = 1'b0,
    SIDE_L = 1'b1
  } tug_side_t;

  // Index of the centre light in a row of n lights (n odd).
  function automatic int centre_idx(input int n);
    return (n - 1) / 2;
  endfunction

endpackage
`default_nettype wire

// File: rtl/press_edge.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : press_edge                                              |
// | Purpose  : 1-bit rising-edge detector, one pulse per 0->1 of level.|
// |            Synchronous active-low reset clears the history to 0.   |
// | Revision : 1.0  initial release                                    |
// +--------------------------------------------------------------------+
module press_edge (
  input  logic clk,
  input  logic reset,
  input  logic level,
  output logic rise
);

  logic prev_q;
  logic prev_d;

  // Next history value is simply the current level.
  always_comb begin
    prev_d = level;
  end

  // History register; cleared to 0 so a key held across reset release
  // registers as a single press on the first active cycle.
  always_ff @(posedge clk) begin
    if (!reset) begin
      prev_q <= 1'b0;
    end else begin
      prev_q <= prev_d;
    end
  end

  assign rise = level & ~prev_q;

endmodule
`default_nettype wire

// File: rtl/tug_playfield_n.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : tug_playfield_n                                         |
// | Purpose  : Tug-of-war playfield. One-hot light row moved by L/R    |
// |            presses, with point detection, per-player scores, a    |
// |            timed win pause and a match-over lock.                  |
// | Config   : TUG_EDGE_DETECT_EN - treat L/R as levels and act only   |
// |            on their rising edges (default: every high cycle is a  |
// |            press).                                                 |
// | Revision : 1.0  initial release                                    |
// +--------------------------------------------------------------------+
module tug_playfield_n
  import tug_pkg::*;
#(
  parameter int NUM_LIGHTS   = 9,
  parameter int SCORE_W      = 3,
  parameter int PAUSE_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  L,
  input  logic                  R,
  output logic [NUM_LIGHTS-1:0] led,
  output logic                  winner_valid,
  output logic                  winner,
  output logic [SCORE_W-1:0]    score_l,
  output logic [SCORE_W-1:0]    score_r,
  output logic                  match_over
);

  localparam int CENTRE = centre_idx(NUM_LIGHTS);
  localparam int CNT_W  = (PAUSE_CYCLES > 1) ? $clog2(PAUSE_CYCLES) : 1;

  localparam logic [NUM_LIGHTS-1:0] LED_CENTRE = {{(NUM_LIGHTS-1){1'b0}}, 1'b1} << CENTRE;
  localparam logic [SCORE_W-1:0]    SCORE_MAX  = {SCORE_W{1'b1}};
  localparam logic [CNT_W-1:0]      CNT_LAST   = CNT_W'(PAUSE_CYCLES - 1);

  // ------------------------------------------------------------------
  // Press qualification
  // ------------------------------------------------------------------
  logic l_evt;
  logic r_evt;

`ifdef TUG_EDGE_DETECT_EN
  // Edge history runs in every state, so a key held through the win
  // pause does not fire again on return to play.
  press_edge u_edge_l (
    .clk   (clk),
    .reset (reset),
    .level (L),
    .rise  (l_evt)
  );

  press_edge u_edge_r (
    .clk   (clk),
    .reset (reset),
    .level (R),
    .rise  (r_evt)
  );
`else
  assign l_evt = L;
  assign r_evt = R;
`endif

  // Simultaneous presses cancel out.
  logic p_l;
  logic p_r;
  assign p_l = l_evt & ~r_evt;
  assign p_r = r_evt & ~l_evt;

  // ------------------------------------------------------------------
  // State
  // ------------------------------------------------------------------
  tug_state_t              state_q,   state_d;
  logic [NUM_LIGHTS-1:0]   led_q,     led_d;
  logic [CNT_W-1:0]        cnt_q,     cnt_d;
  logic [SCORE_W-1:0]      score_l_q, score_l_d;
  logic [SCORE_W-1:0]      score_r_q, score_r_d;
  tug_side_t               winner_q,  winner_d;

  logic point_l;
  logic point_r;
  assign point_l = p_l & led_q[NUM_LIGHTS-1];
  assign point_r = p_r & led_q[0];

  // Next-state logic: light movement, scoring, pause timing and lock.
  always_comb begin
    state_d   = state_q;
    led_d     = led_q;
    cnt_d     = cnt_q;
    score_l_d = score_l_q;
    score_r_d = score_r_q;
    winner_d  = winner_q;

    case (state_q)
      PLAY: begin
        if (point_l) begin
          winner_d  = SIDE_L;
          score_l_d = score_l_q + SCORE_W'(1);
          led_d     = '0;
          cnt_d     = '0;
          // Compare the pre-increment value so the terminal score can never wrap.
          state_d   = (score_l_q == SCORE_MAX - SCORE_W'(1)) ? MATCH_OVER : WIN;
        end else if (point_r) begin
          winner_d  = SIDE_R;
          score_r_d = score_r_q + SCORE_W'(1);
          led_d     = '0;
          cnt_d     = '0;
          state_d   = (score_r_q == SCORE_MAX - SCORE_W'(1)) ? MATCH_OVER : WIN;
        end else if (p_l) begin
          led_d = led_q << 1;
        end else if (p_r) begin
          led_d = led_q >> 1;
        end
      end

      WIN: begin
        // Entered with cnt = 0, so the pause lasts exactly PAUSE_CYCLES cycles.
        if (cnt_q == CNT_LAST) begin
          state_d = PLAY;
          led_d   = LED_CENTRE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      MATCH_OVER: begin
        led_d = '0;
      end

      default: begin
        state_d = PLAY;
        led_d   = LED_CENTRE;
        cnt_d   = '0;
      end
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= PLAY;
      led_q     <= LED_CENTRE;
      cnt_q     <= '0;
      score_l_q <= '0;
      score_r_q <= '0;
      winner_q  <= SIDE_R;
    end else begin
      state_q   <= state_d;
      led_q     <= led_d;
      cnt_q     <= cnt_d;
      score_l_q <= score_l_d;
      score_r_q <= score_r_d;
      winner_q  <= winner_d;
    end
  end

  // ------------------------------------------------------------------
  // Outputs
  // ------------------------------------------------------------------
  assign led          = led_q;
  assign winner_valid = (state_q == WIN);
  assign winner       = winner_q;
  assign score_l      = score_l_q;
  assign score_r      = score_r_q;
  assign match_over   = (state_q == MATCH_OVER);

endmodule
`default_nettype wire
